// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART_TX between NUM_REQ requesters.
// A 1- or 2-byte frame is latched from the winning requester and sent
// LSB byte first through the P_DATA/DATA_VALID/busy handshake.
// Arbitration is round robin by default. Define UART_ARB_FIXED_PRIO_EN
// to use fixed priority instead, where the lowest index wins.
// All outputs are registered.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_len,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             tx_busy,
  output logic [DATA_WIDTH-1:0]            tx_p_data,
  output logic                             tx_data_valid,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             arb_busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = 2*DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_END} state_t;

  state_t                  state, state_d;
  logic [PW-1:0]           data_q, data_d;
  logic                    len_q, len_d;
  logic                    byte_idx, idx_d;
  logic [NUM_REQ-1:0]      ready_d;
  logic [DATA_WIDTH-1:0]   pd_d;
  logic                    dv_d;
  logic [IDW-1:0]          grant_d;
  logic                    busy_d;

  logic                    found;
  logic [IDW-1:0]          sel;
  logic                    accept;

  assign accept = (state == IDLE) && found && !tx_busy;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest valid index wins.
  always_comb begin
    found = |req_valid;
    sel   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (req_valid[k]) sel = IDW'(k);
  end
`else
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cand;

  // Round robin: pick the first valid index after the last grant, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // The pointer starts at the last index, so requester 0 has priority first.
  always_ff @(posedge CLK) begin
    if (RST)         rr_ptr <= IDW'(NUM_REQ-1);
    else if (accept) rr_ptr <= sel;
  end
`endif

  // FSM next state and next values of the registered outputs and frame.
  always_comb begin
    state_d = state;
    data_d  = data_q;
    len_d   = len_q;
    idx_d   = byte_idx;
    ready_d = '0;
    pd_d    = tx_p_data;
    dv_d    = 1'b0;
    grant_d = grant_id;
    busy_d  = arb_busy;
    case (state)
      IDLE: begin
        if (accept) begin
          ready_d[sel] = 1'b1;
          data_d       = req_data[int'(sel)*PW +: PW];
          len_d        = req_len[sel];
          grant_d      = sel;
          busy_d       = 1'b1;
          idx_d        = 1'b0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        pd_d    = byte_idx ? data_q[PW-1:DATA_WIDTH] : data_q[DATA_WIDTH-1:0];
        dv_d    = 1'b1;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (tx_busy) state_d = WAIT_END;
      end
      WAIT_END: begin
        if (!tx_busy) begin
          if (byte_idx < len_q) begin
            idx_d   = 1'b1;
            state_d = LOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, frame and output registers; reset aborts any frame in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      data_q        <= '0;
      len_q         <= 1'b0;
      byte_idx      <= 1'b0;
      req_ready     <= '0;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
      grant_id      <= '0;
      arb_busy      <= 1'b0;
    end else begin
      state         <= state_d;
      data_q        <= data_d;
      len_q         <= len_d;
      byte_idx      <= idx_d;
      req_ready     <= ready_d;
      tx_p_data     <= pd_d;
      tx_data_valid <= dv_d;
      grant_id      <= grant_d;
      arb_busy      <= busy_d;
    end
  end

endmodule
